// File: rtl/ball_pkg.sv
// Shared types and default geometry for the ball, paddle and brick blocks.
package ball_pkg;

    localparam int unsigned DEF_COORD_W   = 10;
    localparam int unsigned DEF_SCREEN_W  = 640;
    localparam int unsigned DEF_SCREEN_H  = 480;
    localparam int unsigned DEF_BALL_SIZE = 20;
    localparam int unsigned DEF_PADDLE_Y  = 460;
    localparam int unsigned DEF_PADDLE_W  = 80;
    localparam int unsigned DEF_INIT_X    = 310;
    localparam int unsigned STEP_CNT_W    = 25;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        RUN   = 2'd1,
        LOST  = 2'd2
    } ball_state_t;

    // DIR_POS is right for x and down for y.
    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/ball_tick.sv
// Step-rate divider: fires once every delay_done+1 enabled cycles.
module ball_tick
    import ball_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [STEP_CNT_W-1:0] delay_done,
    output logic                  step_c
);

    logic [STEP_CNT_W-1:0] count_q;

    assign step_c = en && (count_q >= delay_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= step_c ? '0 : count_q + STEP_CNT_W'(1);
        end
    end

endmodule

// File: rtl/ball_ctrl.sv
// Ball motion controller: serve tracking, stepped movement, wall/paddle/brick bounces, loss.
module ball_ctrl
    import ball_pkg::*;
#(
    parameter int unsigned COORD_W   = DEF_COORD_W,
    parameter int unsigned SCREEN_W  = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H  = DEF_SCREEN_H,
    parameter int unsigned BALL_SIZE = DEF_BALL_SIZE,
    parameter int unsigned PADDLE_Y  = DEF_PADDLE_Y,
    parameter int unsigned PADDLE_W  = DEF_PADDLE_W,
    parameter int unsigned INIT_X    = DEF_INIT_X
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STEP_CNT_W-1:0] delay_done,
    input  logic [COORD_W-1:0]    paddle_x,
    input  logic                  launch,
    input  logic                  brick_hit,
    output logic [COORD_W-1:0]    ball_x,
    output logic [COORD_W-1:0]    ball_y,
    output logic                  moving,
    output logic                  step,
    output logic                  ball_lost
);

    localparam int unsigned        EW      = COORD_W + 1;
    localparam logic [COORD_W-1:0] SERVE_Y = COORD_W'(PADDLE_Y - BALL_SIZE);

    ball_state_t        state_q, state_d;
    logic [COORD_W-1:0] x_d, y_d;
    logic               dx_q, dx_d, dy_q, dy_d;
    logic               pend_q, pend_d;
    logic               step_d;
    logic               tick_en, tick_clr, tick_fire_c;

    // Edge sums carry one extra bit so nothing wraps near the field limits.
    logic [EW-1:0] x_far, y_far, pad_far, serve_x;
    logic          paddle_ov;

    assign x_far     = EW'(ball_x) + EW'(BALL_SIZE);
    assign y_far     = EW'(ball_y) + EW'(BALL_SIZE);
    assign pad_far   = EW'(paddle_x) + EW'(PADDLE_W);
    assign serve_x   = EW'(paddle_x) + EW'(PADDLE_W / 2) - EW'(BALL_SIZE / 2);
    assign paddle_ov = (x_far >= EW'(paddle_x)) && (EW'(ball_x) <= pad_far);

    ball_tick u_tick (
        .clk        (clk),
        .rst        (rst),
        .en         (tick_en),
        .clr        (tick_clr),
        .delay_done (delay_done),
        .step_c     (tick_fire_c)
    );

    // Next-state and move rules.
    always_comb begin
        state_d  = state_q;
        x_d      = ball_x;
        y_d      = ball_y;
        dx_d     = dx_q;
        dy_d     = dy_q;
        pend_d   = pend_q;
        step_d   = 1'b0;
        tick_en  = 1'b0;
        tick_clr = 1'b0;
        case (state_q)
            SERVE: begin
                x_d = COORD_W'(serve_x);
                y_d = SERVE_Y;
                if (launch) begin
                    state_d  = RUN;
                    dx_d     = DIR_POS;
                    dy_d     = DIR_NEG;
                    pend_d   = 1'b0;
                    tick_clr = 1'b1;
                end
            end
            RUN: begin
                tick_en = 1'b1;
                if (brick_hit) pend_d = 1'b1;
                if (tick_fire_c) begin
                    step_d = 1'b1;
                    pend_d = 1'b0;
                    if (dy_q == DIR_POS && y_far >= EW'(SCREEN_H - 1) && !paddle_ov) begin
                        state_d = LOST;
                    end else begin
                        if (dy_q == DIR_POS && y_far == EW'(PADDLE_Y) && paddle_ov)
                            dy_d = DIR_NEG;
                        else if (pend_q || brick_hit)
                            dy_d = ~dy_q;
                        else if (ball_y == '0 && dy_q == DIR_NEG)
                            dy_d = DIR_POS;
                        if (ball_x == '0 && dx_q == DIR_NEG)
                            dx_d = DIR_POS;
                        else if (x_far >= EW'(SCREEN_W - 1) && dx_q == DIR_POS)
                            dx_d = DIR_NEG;
                        x_d = (dx_d == DIR_POS) ? ball_x + COORD_W'(1) : ball_x - COORD_W'(1);
                        y_d = (dy_d == DIR_POS) ? ball_y + COORD_W'(1) : ball_y - COORD_W'(1);
                    end
                end
            end
            LOST: begin
                if (launch) state_d = SERVE;
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SERVE;
            ball_x    <= COORD_W'(INIT_X);
            ball_y    <= SERVE_Y;
            dx_q      <= DIR_POS;
            dy_q      <= DIR_NEG;
            pend_q    <= 1'b0;
            step      <= 1'b0;
            moving    <= 1'b0;
            ball_lost <= 1'b0;
        end else begin
            state_q   <= state_d;
            ball_x    <= x_d;
            ball_y    <= y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            pend_q    <= pend_d;
            step      <= step_d;
            moving    <= (state_d == RUN);
            ball_lost <= (state_d == LOST);
        end
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: directed scenarios plus randomized games against a behavioural model.
module tb_ball_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] delay_done;
    logic [9:0]  paddle_x;
    logic        launch;
    logic        brick_hit;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic        moving;
    logic        step;
    logic        ball_lost;

    always #5 clk = ~clk;

    ball_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .delay_done (delay_done),
        .paddle_x   (paddle_x),
        .launch     (launch),
        .brick_hit  (brick_hit),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .moving     (moving),
        .step       (step),
        .ball_lost  (ball_lost)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = serving, 1 = in play, 2 = lost. Directions are +1/-1.
    int mode, mx, my, mdx, mdy, mwait;
    bit mpend, mstep;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit hit, over;
        if (rst) begin
            mode = 0; mx = 310; my = 440; mdx = 1; mdy = -1;
            mwait = 0; mpend = 0; mstep = 0;
            return;
        end
        mstep = 0;
        if (mode == 0) begin
            mx = (int'(paddle_x) + 40 - 10) & 1023;
            my = 440;
            if (launch) begin
                mode = 1; mdx = 1; mdy = -1; mwait = 0; mpend = 0;
            end
        end else if (mode == 1) begin
            if (mwait < int'(delay_done)) begin
                mwait++;
                if (brick_hit) mpend = 1;
            end else begin
                mwait = 0;
                mstep = 1;
                hit   = mpend || brick_hit;
                mpend = 0;
                over  = (mx + 20 >= int'(paddle_x)) && (mx <= int'(paddle_x) + 80);
                if (mdy > 0 && my + 20 >= 479 && !over) begin
                    mode = 2;
                end else begin
                    if (mdy > 0 && my + 20 == 460 && over) mdy = -1;
                    else if (hit) mdy = -mdy;
                    else if (my == 0 && mdy < 0) mdy = 1;
                    if (mx == 0 && mdx < 0) mdx = 1;
                    else if (mx + 20 >= 639 && mdx > 0) mdx = -1;
                    mx = (mx + mdx) & 1023;
                    my = (my + mdy) & 1023;
                end
            end
        end else if (launch) begin
            mode = 0;
        end
    endtask

    task automatic compare_all();
        check("ball_x", 32'(ball_x), 32'(mx));
        check("ball_y", 32'(ball_y), 32'(my));
        check("moving", 32'(moving), 32'(mode == 1));
        check("ball_lost", 32'(ball_lost), 32'(mode == 2));
        check("step", 32'(step), 32'(mstep));
    endtask

    // One clock: model follows the same edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int games_lost;
        rst = 1'b1; launch = 1'b0; brick_hit = 1'b0; paddle_x = 10'd100; delay_done = 25'd3;
        mode = 0; mx = 0; my = 0; mdx = 1; mdy = -1; mwait = 0; mpend = 0; mstep = 0;
        games_lost = 0;

        tick(); tick();
        check("reset_x", 32'(ball_x), 32'd310);
        check("reset_y", 32'(ball_y), 32'd440);
        check("reset_moving", 32'(moving), 32'd0);

        rst = 1'b0;
        tick();
        check("serve_x", 32'(ball_x), 32'd130);
        check("serve_y", 32'(ball_y), 32'd440);
        check("serve_moving", 32'(moving), 32'd0);

        launch = 1'b1; tick(); launch = 1'b0;
        check("launch_moving", 32'(moving), 32'd1);
        repeat (3) begin
            tick();
            check("rate_idle", 32'(step), 32'd0);
        end
        tick();
        check("rate_step", 32'(step), 32'd1);
        check("rate_x", 32'(ball_x), 32'd131);
        check("rate_y", 32'(ball_y), 32'd439);

        // Two hits between steps flip dy once.
        brick_hit = 1'b1; tick(); brick_hit = 1'b0;
        tick();
        brick_hit = 1'b1; tick(); brick_hit = 1'b0;
        tick();
        check("brick_step", 32'(step), 32'd1);
        check("brick_y", 32'(ball_y), 32'd440);
        check("brick_x", 32'(ball_x), 32'd132);

        // Descending onto the paddle at y=440 bounces back up.
        repeat (4) tick();
        check("paddle_y", 32'(ball_y), 32'd439);
        check("paddle_x", 32'(ball_x), 32'd133);

        // Reset with counter at 2 and a pending hit.
        brick_hit = 1'b1; tick(); brick_hit = 1'b0;
        tick();
        rst = 1'b1; tick();
        check("midrst_x", 32'(ball_x), 32'd310);
        check("midrst_y", 32'(ball_y), 32'd440);
        check("midrst_step", 32'(step), 32'd0);
        check("midrst_moving", 32'(moving), 32'd0);
        rst = 1'b0; tick();

        for (int g = 0; g < 10; g++) begin
            bit track;
            track      = (g % 3 == 0);
            delay_done = 25'($urandom_range(0, 1));
            paddle_x   = 10'($urandom_range(0, 560));
            tick();
            launch = 1'b1; tick(); launch = 1'b0;
            for (int c = 0; c < 3500 && mode != 2; c++) begin
                brick_hit = ($urandom_range(0, 39) == 0);
                launch    = ($urandom_range(0, 199) == 0);
                if (track) begin
                    int p;
                    p = mx - 30;
                    if (p < 0) p = 0;
                    if (p > 560) p = 560;
                    paddle_x = 10'(p);
                end else if ($urandom_range(0, 499) == 0) begin
                    paddle_x = 10'($urandom_range(0, 560));
                end
                tick();
            end
            brick_hit = 1'b0; launch = 1'b0;
            if (mode == 2) begin
                games_lost++;
                repeat (4) begin
                    brick_hit = $urandom_range(0, 1) == 1;
                    tick();
                end
                brick_hit = 1'b0;
                launch = 1'b1; tick(); launch = 1'b0;
                check("relaunch_lost", 32'(ball_lost), 32'd0);
                tick();
            end else begin
                rst = 1'b1; tick(); rst = 1'b0; tick();
            end
        end
        check("some_game_lost", 32'(games_lost > 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
